// File: rtl/xbar_slave_mem.sv
// Word-addressed SRAM slave behind one crossbar slave port; answers each request with a one-cycle sack.
// Optional feature macro XBAR_SLV_ERR_EN adds the serr port and an out-of-range address check.
module xbar_slave_mem #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire  [DATA_W-1:0] srw,
    input  logic [31:0]       saddr,
    input  logic              sreq,
    input  logic              scmd,
    output logic              sack
`ifdef XBAR_SLV_ERR_EN
    ,
    output logic              serr
`endif
);

    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t                 state, state_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic [DATA_W-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  idx_q, idx_src;
    logic                   cmd_q, cmd_src;
    logic [DATA_W-1:0]      wdata_q, wdata_src, rdata_q;
    logic                   err_src;
    logic                   live, accept, enter_ack, drive;
    logic                   addr_unused;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (sreq) begin
                    if (WAIT_STATES == 0) begin
                        state_next = ACK;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_next = ACK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With zero wait states the accepting edge is also the ACK edge, so take the live bus then.
    assign live      = (state == IDLE);
    assign accept    = live && sreq && !reset;
    assign enter_ack = !reset && (state_next == ACK) && (state != ACK);
    assign idx_src   = live ? saddr[DEPTH_LOG2+1:2] : idx_q;
    assign cmd_src   = live ? scmd : cmd_q;
    assign wdata_src = live ? srw : wdata_q;

`ifdef XBAR_SLV_ERR_EN
    logic err_q;
    assign err_src = live ? (|saddr[30:DEPTH_LOG2+2]) : err_q;
    always_ff @(posedge clk) begin
        if (accept) err_q <= |saddr[30:DEPTH_LOG2+2];
    end
    assign serr = (state == ACK) && err_q;
`else
    assign err_src = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= saddr[DEPTH_LOG2+1:2];
            cmd_q   <= scmd;
            wdata_q <= srw;
        end
        if (enter_ack) begin
            if (cmd_src && !err_src) mem[idx_src] <= wdata_src;
            rdata_q <= err_src ? ERR_DATA : mem[idx_src];
        end
    end

    // Also gated on live scmd so a master already presenting a write never collides with read data.
    assign drive = (state == ACK) && !cmd_q && !scmd;
    assign srw   = drive ? rdata_q : {DATA_W{1'bz}};
    assign sack  = (state == ACK);

    assign addr_unused = ^{saddr[31:DEPTH_LOG2+2], saddr[1:0]};

endmodule

// File: tb/tb_xbar_slave_mem.sv
// Directed bench for xbar_slave_mem (default parameters); a weak pullup makes a released srw read as all ones.
// Define XBAR_SLV_ERR_EN for both files to exercise the address-error path.
module tb_xbar_slave_mem;

    localparam logic [31:0] REL = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        sreq;
    logic        scmd;
    logic [31:0] saddr;
    logic [31:0] drv;
    logic        drv_en;
    logic        sack;
    wire  [31:0] srw;
`ifdef XBAR_SLV_ERR_EN
    logic        serr;
`endif

    int vectors     = 0;
    int miscompares = 0;

    assign srw = drv_en ? drv : 32'hzzzz_zzzz;
    pullup pu (srw);

    always #5 clk = ~clk;

    xbar_slave_mem dut (
        .clk   (clk),
        .reset (reset),
        .srw   (srw),
        .saddr (saddr),
        .sreq  (sreq),
        .scmd  (scmd),
        .sack  (sack)
`ifdef XBAR_SLV_ERR_EN
        ,
        .serr  (serr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after an edge; request is accepted at the next edge, sack expected two edges later.
    task automatic txn(input string tag, input logic cmd, input logic [31:0] addr,
                       input logic [31:0] data, input logic exp_err);
        sreq   = 1'b1;
        scmd   = cmd;
        saddr  = addr;
        drv    = data;
        drv_en = cmd;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            check({tag, " sack"}, 32'(sack), 32'(i == 3));
            if (!cmd) check({tag, " srw"}, srw, (i == 3) ? data : REL);
`ifdef XBAR_SLV_ERR_EN
            check({tag, " serr"}, 32'(serr), 32'((i == 3) && exp_err));
`endif
            if (i == 3) begin
                sreq   = 1'b0;
                drv_en = 1'b0;
            end
        end
        @(posedge clk); #1;
        check({tag, " sack after"}, 32'(sack), 32'd0);
        if (!cmd) check({tag, " srw after"}, srw, REL);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b2b_addr [3];
        logic [31:0] b2b_data [3];
        logic [31:0] exp_data;
        logic        exp_ack;
        b2b_addr = '{32'h0000_0010, 32'h0000_0014, 32'h8000_0018};
        b2b_data = '{32'hA5A5_0001, 32'h0BAD_0005, 32'h0600_C0DE};

        reset  = 1'b1;
        sreq   = 1'b0;
        scmd   = 1'b0;
        saddr  = '0;
        drv    = '0;
        drv_en = 1'b0;
        #2;
        check("reset sack", 32'(sack), 32'd0);
        check("reset srw", srw, REL);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        txn("write w4", 1'b1, 32'h0000_0010, 32'hA5A5_0001, 1'b0);
        txn("read w4 bit31", 1'b0, 32'h8000_0010, 32'hA5A5_0001, 1'b0);
        txn("write w8 zero", 1'b1, 32'h0000_0020, 32'h0000_0000, 1'b0);
        txn("write w5", 1'b1, 32'h0000_0014, 32'h0BAD_0005, 1'b0);
        txn("write w6", 1'b1, 32'h0000_0018, 32'h0600_C0DE, 1'b0);

        // Three reads with sreq held high: sack after edges 3, 7, 11.
        sreq  = 1'b1;
        scmd  = 1'b0;
        saddr = b2b_addr[0];
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
            exp_ack  = (c % 4 == 3);
            exp_data = exp_ack ? b2b_data[c / 4] : REL;
            check("b2b sack", 32'(sack), 32'(exp_ack));
            check("b2b srw", srw, exp_data);
            if (exp_ack && c < 11) saddr = b2b_addr[c / 4 + 1];
            if (c == 11) sreq = 1'b0;
        end
        @(posedge clk); #1;
        check("b2b sack after", 32'(sack), 32'd0);

        // Reset during WAIT of a write aborts it.
        sreq   = 1'b1;
        scmd   = 1'b1;
        saddr  = 32'h0000_0020;
        drv    = 32'h1234_5678;
        drv_en = 1'b1;
        @(posedge clk); #1;
        check("abort wait sack", 32'(sack), 32'd0);
        #2 reset = 1'b1;
        sreq   = 1'b0;
        drv_en = 1'b0;
        #1 check("abort in reset sack", 32'(sack), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("abort no sack", 32'(sack), 32'd0);
        end
        txn("read w8 after abort", 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0);

        // Reset asserted mid-ACK drops sack and srw without a clock edge.
        sreq  = 1'b1;
        scmd  = 1'b0;
        saddr = 32'h0000_0010;
        repeat (3) @(posedge clk);
        #1;
        check("ack before reset sack", 32'(sack), 32'd1);
        check("ack before reset srw", srw, 32'hA5A5_0001);
        #2 reset = 1'b1;
        #1;
        check("ack reset sack", 32'(sack), 32'd0);
        check("ack reset srw", srw, REL);
        sreq = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        txn("read w5 after reset", 1'b0, 32'h0000_0014, 32'h0BAD_0005, 1'b0);

`ifdef XBAR_SLV_ERR_EN
        txn("write w0", 1'b1, 32'h0000_0000, 32'h0000_0C0C, 1'b0);
        txn("err read", 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1);
        txn("err write", 1'b1, 32'h0000_1000, 32'h7777_7777, 1'b1);
        txn("read w0 after err", 1'b0, 32'h0000_0000, 32'h0000_0C0C, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
